absorb_stream: RTL and testbench

- Sequential, parametrised successor of the combinational lane absorber.
- Accepts a ready/valid byte stream of DWIDTH-bit beats and owns the 1600-bit Keccak state register.
- XORs beats into the rate portion of the state, splits beats that straddle a rate boundary, and holds the remainder in an internal carry buffer.
- Requests a permutation at every full block, applies SHA-3 or SHAKE padding after the last beat, and signals completion to the squeeze stage.

---
 rtl/absorb_stream_pkg.sv | 47 ++++
 rtl/absorb_stream_if.sv | 18 +
 rtl/absorb_stream_lane_xor_mux.sv | 34 +++
 rtl/absorb_stream.sv | 241 ++++++++++++++++++++++++
 tb/tb_absorb_stream.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/absorb_stream_pkg.sv
// rtl/absorb_stream_pkg.sv - Keccak sponge absorb constants, types and helpers
//   state_t      : 1600-bit Keccak state, indexed [x][y][z]
//   mode_e       : hash mode selector (SHA3-224/256/384/512, SHAKE128/256)
//   rate_bytes() : rate in bytes for a mode
//   pad_byte()   : domain-separation pad byte for a mode
//   keep_to_mask(): expand an 8-bit byte keep into a 64-bit lane mask
package absorb_stream_pkg;

  localparam int ROW_SIZE  = 5;
  localparam int COL_SIZE  = 5;
  localparam int LANE_SIZE = 64;

  localparam logic [7:0] SHA3_PAD  = 8'h06;
  localparam logic [7:0] SHAKE_PAD = 8'h1F;
  localparam logic [7:0] FINAL_PAD = 8'h80;

  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;

  typedef enum logic [2:0] {
    MODE_SHA3_224 = 3'd0,
    MODE_SHA3_256 = 3'd1,
    MODE_SHA3_384 = 3'd2,
    MODE_SHA3_512 = 3'd3,
    MODE_SHAKE128 = 3'd4,
    MODE_SHAKE256 = 3'd5
  } mode_e;

  function automatic logic [7:0] rate_bytes(mode_e m);
    case (m)
      MODE_SHA3_224: rate_bytes = 8'd144;
      MODE_SHA3_256: rate_bytes = 8'd136;
      MODE_SHA3_384: rate_bytes = 8'd104;
      MODE_SHA3_512: rate_bytes = 8'd72;
      MODE_SHAKE128: rate_bytes = 8'd168;
      default:       rate_bytes = 8'd136;
    endcase
  endfunction

  function automatic logic [7:0] pad_byte(mode_e m);
    pad_byte = (m == MODE_SHAKE128 || m == MODE_SHAKE256) ? SHAKE_PAD : SHA3_PAD;
  endfunction

  function automatic logic [63:0] keep_to_mask(logic [7:0] keep);
    for (int b = 0; b < 8; b++) keep_to_mask[8*b +: 8] = {8{keep[b]}};
  endfunction

endpackage

// File: rtl/absorb_stream_if.sv
// rtl/absorb_stream_if.sv - byte stream beat channel into the absorb stage
//   tdata  : DWIDTH-bit beat, little-endian bytes
//   tkeep  : byte valid mask, low contiguous bytes
//   tlast  : final beat of the message
//   tvalid : beat valid (master)
//   tready : beat accepted on tvalid && tready (slave)
interface absorb_stream_if #(
  parameter int DWIDTH = 256
);
  logic [DWIDTH-1:0]   tdata;
  logic [DWIDTH/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/absorb_stream_lane_xor_mux.sv
// rtl/absorb_stream_lane_xor_mux.sv - XOR a run of 64-bit lanes into the Keccak state
//   state_i     : current state
//   off_i       : linear lane index receiving lane_data_i[0]
//   lane_data_i : LANES lanes to XOR in
//   lane_mask_i : per-lane byte keep; bytes with keep=0 contribute nothing
//   lane_lim_i  : lanes at or above this linear index are left untouched
//   state_o     : resulting state
module lane_xor_mux
  import absorb_stream_pkg::*;
#(
  parameter int LANES = 4
) (
  input  state_t                  state_i,
  input  logic [4:0]              off_i,
  input  logic [LANES-1:0][63:0]  lane_data_i,
  input  logic [LANES-1:0][7:0]   lane_mask_i,
  input  logic [4:0]              lane_lim_i,
  output state_t                  state_o
);

  // Linear lane j lives at x = j%5, y = j/5; loops use constant indices only.
  always_comb begin
    state_o = state_i;
    for (int j = 0; j < 25; j++) begin
      for (int k = 0; k < LANES; k++) begin
        if ((int'(off_i) + k == j) && (j < int'(lane_lim_i))) begin
          state_o[j%5][j/5] = state_o[j%5][j/5] ^
                              (lane_data_i[k] & keep_to_mask(lane_mask_i[k]));
        end
      end
    end
  end

endmodule

// File: rtl/absorb_stream.sv
// rtl/absorb_stream.sv - sequential Keccak absorb stage with carry buffer and padding
//   clk, rst      : clock, synchronous active-high reset
//   mode_i        : hash mode, sampled on start_i
//   start_i       : clear state and begin a new message
//   s             : message beat stream (slave)
//   perm_req_o    : level request for Keccak-f, held until perm_done_i
//   perm_done_i   : one-cycle pulse, perm_state_i valid in that cycle
//   perm_state_i  : permuted state
//   state_o       : current state register
//   busy_o        : message in flight
//   done_o        : final padded block has been permuted
//   err_o         : sticky bad mode / short non-last beat
module absorb_stream
  import absorb_stream_pkg::*;
#(
  parameter int DWIDTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         mode_i,
  input  logic               start_i,
  absorb_stream_if.slave     s,
  output logic               perm_req_o,
  input  logic               perm_done_i,
  input  state_t             perm_state_i,
  output state_t             state_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int LANES_IN   = DWIDTH / 64;
  localparam int CARRY_W    = DWIDTH - 64;
  // A one-lane beat can never straddle a lane-aligned rate boundary, but keep
  // the buffer at least one lane wide so the declarations stay legal.
  localparam int CARRY_BITS = (CARRY_W > 0) ? CARRY_W : 64;
  localparam int CARRY_LN   = CARRY_BITS / 64;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ABSORB = 3'd1;
  localparam logic [2:0] S_PERM   = 3'd2;
  localparam logic [2:0] S_CARRY  = 3'd3;
  localparam logic [2:0] S_PAD    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  generate
    if ((DWIDTH % 64) != 0 || DWIDTH < 64 || DWIDTH > 512) begin : g_bad_dwidth
      $error("absorb_stream: DWIDTH must be a multiple of 64 in 64..512");
    end
  endgenerate

  logic [2:0]                    fsm;
  mode_e                         mode;
  state_t                        st;
  logic [7:0]                    byte_cnt;
  logic [CARRY_LN-1:0][63:0]     carry_data;
  logic [CARRY_LN-1:0][7:0]      carry_keep;
  logic                          carry_vld;
  logic                          last_pending;
  logic                          pad_applied;
  logic                          err;

  logic [LANES_IN-1:0][63:0]     beat_lanes;
  logic [LANES_IN-1:0][7:0]      beat_keep;
  logic [7:0]                    rate_b;
  logic [4:0]                    lane_lim;
  logic [4:0]                    a_lanes;
  logic [6:0]                    n_keep;
  logic [8:0]                    sum_cnt;
  logic [7:0]                    carry_cnt;
  logic [CARRY_LN-1:0][63:0]     carry_data_n;
  logic [CARRY_LN-1:0][7:0]      carry_keep_n;
  logic [4:0]                    mux_off;
  logic [LANES_IN-1:0][63:0]     mux_data;
  logic [LANES_IN-1:0][7:0]      mux_mask;
  state_t                        mux_state;
  state_t                        pad_state;

  assign beat_lanes = s.tdata;
  assign beat_keep  = s.tkeep;
  assign rate_b     = rate_bytes(mode);
  assign lane_lim   = rate_b[7:3];
  // Lanes of the current beat that still fit below the rate boundary.
  assign a_lanes    = lane_lim - byte_cnt[7:3];
  assign n_keep     = 7'($countones(s.tkeep));
  assign sum_cnt    = {1'b0, byte_cnt} + {2'b00, n_keep};
  assign carry_cnt  = 8'($countones(carry_keep));

  // Beat lanes beyond the rate, realigned to start at carry lane 0.
  always_comb begin
    carry_data_n = '0;
    carry_keep_n = '0;
    for (int c = 0; c < CARRY_LN; c++) begin
      for (int k = 0; k < LANES_IN; k++) begin
        if (k == int'(a_lanes) + c) begin
          carry_data_n[c] = beat_lanes[k];
          carry_keep_n[c] = beat_keep[k];
        end
      end
    end
  end

  // One XOR network serves the beat, the carry replay and the pad byte.
  always_comb begin
    mux_off  = byte_cnt[7:3];
    mux_data = beat_lanes;
    mux_mask = beat_keep;
    case (fsm)
      S_CARRY: begin
        mux_off  = '0;
        mux_data = '0;
        mux_mask = '0;
        for (int k = 0; k < CARRY_LN; k++) begin
          mux_data[k] = carry_data[k];
          mux_mask[k] = carry_keep[k];
        end
      end
      S_PAD: begin
        mux_data    = '0;
        mux_mask    = '0;
        mux_data[0] = {56'd0, pad_byte(mode)} << {byte_cnt[2:0], 3'b000};
        mux_mask[0] = 8'hFF;
      end
      default: ;
    endcase
  end

  lane_xor_mux #(.LANES(LANES_IN)) u_lane_xor_mux (
    .state_i     (st),
    .off_i       (mux_off),
    .lane_data_i (mux_data),
    .lane_mask_i (mux_mask),
    .lane_lim_i  (lane_lim),
    .state_o     (mux_state)
  );

  // The rate is lane aligned, so the closing 0x80 is always byte 7 of the
  // last rate lane; XOR keeps it correct when it lands on the 0x06/0x1F byte.
  always_comb begin
    pad_state = mux_state;
    for (int j = 0; j < 25; j++) begin
      if (j == int'(lane_lim) - 1) begin
        pad_state[j%5][j/5][63:56] = pad_state[j%5][j/5][63:56] ^ FINAL_PAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm          <= S_IDLE;
      mode         <= MODE_SHA3_224;
      st           <= '0;
      byte_cnt     <= '0;
      carry_data   <= '0;
      carry_keep   <= '0;
      carry_vld    <= 1'b0;
      last_pending <= 1'b0;
      pad_applied  <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            if (mode_i <= 3'd5) begin
              fsm          <= S_ABSORB;
              mode         <= mode_e'(mode_i);
              st           <= '0;
              byte_cnt     <= '0;
              carry_data   <= '0;
              carry_keep   <= '0;
              carry_vld    <= 1'b0;
              last_pending <= 1'b0;
              pad_applied  <= 1'b0;
              err          <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_ABSORB: begin
          if (s.tvalid) begin
            st <= mux_state;
            if (!s.tlast && (s.tkeep != '1)) err <= 1'b1;
            if (sum_cnt >= {1'b0, rate_b}) begin
              carry_data   <= carry_data_n;
              carry_keep   <= carry_keep_n;
              carry_vld    <= |carry_keep_n;
              byte_cnt     <= '0;
              last_pending <= s.tlast;
              fsm          <= S_PERM;
            end else begin
              byte_cnt <= sum_cnt[7:0];
              if (s.tlast) fsm <= S_PAD;
            end
          end
        end
        S_PERM: begin
          if (perm_done_i) begin
            st <= perm_state_i;
            if (carry_vld) begin
              fsm <= S_CARRY;
            end else if (last_pending) begin
              // Cleared here so the pad block's own permutation ends in DONE.
              last_pending <= 1'b0;
              fsm          <= S_PAD;
            end else if (pad_applied) begin
              fsm <= S_DONE;
            end else begin
              fsm <= S_ABSORB;
            end
          end
        end
        S_CARRY: begin
          st        <= mux_state;
          byte_cnt  <= carry_cnt;
          carry_vld <= 1'b0;
          if (last_pending) begin
            last_pending <= 1'b0;
            fsm          <= S_PAD;
          end else begin
            fsm <= S_ABSORB;
          end
        end
        S_PAD: begin
          st          <= pad_state;
          pad_applied <= 1'b1;
          fsm         <= S_PERM;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign s.tready   = (fsm == S_ABSORB);
  assign perm_req_o = (fsm == S_PERM);
  assign busy_o     = (fsm != S_IDLE) && (fsm != S_DONE);
  assign done_o     = (fsm == S_DONE);
  assign err_o      = err;
  assign state_o    = st;

endmodule

// File: tb/tb_absorb_stream.sv
// tb/tb_absorb_stream.sv - directed self-checking bench for absorb_stream
module tb_absorb_stream;
  import absorb_stream_pkg::*;

  localparam int DW = 256;
  localparam int NB = DW / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] mode_i = 3'd0;
  logic       start_i = 1'b0;
  logic       perm_req_o;
  logic       perm_done_i = 1'b0;
  state_t     perm_state_i = '0;
  state_t     state_o;
  logic       busy_o, done_o, err_o;

  always #5 clk = ~clk;

  absorb_stream_if #(.DWIDTH(DW)) s_if ();

  absorb_stream #(.DWIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode_i       (mode_i),
    .start_i      (start_i),
    .s            (s_if),
    .perm_req_o   (perm_req_o),
    .perm_done_i  (perm_done_i),
    .perm_state_i (perm_state_i),
    .state_o      (state_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] msg [0:255];
  state_t     exp_pre [$];
  state_t     first_snap;
  logic       post1 [0:7];
  logic       post2 [0:7];
  logic       hold_ready_bad, hold_stable_bad;

  // Stand-in permutation: any fixed bijection is enough to track blocks.
  function automatic state_t perm_fn(state_t s);
    logic [1599:0] f;
    f = s;
    f = {f[1598:0], f[1599]} ^ {25{64'h0123_4567_89AB_CDEF}};
    perm_fn = f;
  endfunction

  function automatic state_t xor_byte(state_t s, int i, logic [7:0] v);
    int lane;
    lane = i / 8;
    s[lane%5][lane/5][8*(i%8) +: 8] = s[lane%5][lane/5][8*(i%8) +: 8] ^ v;
    xor_byte = s;
  endfunction

  function automatic int rate_of(int m);
    case (m)
      0: rate_of = 144;
      1: rate_of = 136;
      2: rate_of = 104;
      3: rate_of = 72;
      4: rate_of = 168;
      default: rate_of = 136;
    endcase
  endfunction

  function automatic int diff_lane(state_t a, state_t b);
    diff_lane = 0;
    for (int j = 24; j >= 0; j--) if (a[j%5][j/5] !== b[j%5][j/5]) diff_lane = j;
  endfunction

  // Byte-serial sponge: records the state presented to every permutation.
  task automatic build_model(int m, int n);
    state_t st;
    int     pos;
    int     rate;
    exp_pre.delete();
    st   = '0;
    pos  = 0;
    rate = rate_of(m);
    for (int i = 0; i < n; i++) begin
      st = xor_byte(st, pos, msg[i]);
      pos++;
      if (pos == rate) begin
        exp_pre.push_back(st);
        st  = perm_fn(st);
        pos = 0;
      end
    end
    st = xor_byte(st, pos, (m >= 4) ? 8'h1F : 8'h06);
    st = xor_byte(st, rate - 1, 8'h80);
    exp_pre.push_back(st);
  endtask

  task automatic pulse_start(logic [2:0] m);
    @(negedge clk);
    mode_i  = m;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic drive_msg(int n, output bit ok);
    int             nb;
    logic [DW-1:0]  data;
    logic [NB-1:0]  keep;
    bit             got, r;
    ok = 1'b1;
    nb = (n == 0) ? 1 : (n + NB - 1) / NB;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < NB; i++) begin
        if (b * NB + i < n) begin
          data[8*i +: 8] = msg[b*NB + i];
          keep[i]        = 1'b1;
        end else begin
          data[8*i +: 8] = 8'hEE;
          keep[i]        = 1'b0;
        end
      end
      s_if.tdata  = data;
      s_if.tkeep  = keep;
      s_if.tlast  = (b == nb - 1);
      s_if.tvalid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 400 && !got; t++) begin
        r = s_if.tready;
        @(negedge clk);
        got = r;
      end
      if (!got) begin
        ok = 1'b0;
        break;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic serve_perms(int hold, output int served);
    bit     found, rb, sb;
    state_t snap;
    int     j;
    served = 0;
    for (int k = 0; k < exp_pre.size(); k++) begin
      found = 1'b0;
      for (int t = 0; t < 600 && !found; t++) begin
        if (perm_req_o === 1'b1) found = 1'b1;
        else @(negedge clk);
      end
      if (!found) break;
      if (k == 0) first_snap = state_o;
      n_cmp++;
      if (state_o !== exp_pre[k]) begin
        n_bad++;
        j = diff_lane(state_o, exp_pre[k]);
        $display("FAIL pre_perm_state[%0d] lane %0d: got %h want %h", k, j,
                 state_o[j%5][j/5], exp_pre[k][j%5][j/5]);
      end
      snap = state_o;
      rb   = 1'b0;
      sb   = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (s_if.tready !== 1'b0) rb = 1'b1;
        if (state_o !== snap || perm_req_o !== 1'b1) sb = 1'b1;
      end
      if (k == 0) begin
        hold_ready_bad  = rb;
        hold_stable_bad = sb;
      end
      perm_state_i = perm_fn(exp_pre[k]);
      perm_done_i  = 1'b1;
      @(negedge clk);
      perm_done_i = 1'b0;
      post1[k]    = s_if.tready;
      @(negedge clk);
      post2[k]    = s_if.tready;
      served++;
    end
  endtask

  task automatic run_msg(int m, int n, int hold, output int served);
    bit     drv_ok;
    state_t fin;
    build_model(m, n);
    pulse_start(3'(m));
    fork
      drive_msg(n, drv_ok);
      serve_perms(hold, served);
    join
    fin = perm_fn(exp_pre[exp_pre.size()-1]);
    n_cmp++;
    if (drv_ok !== 1'b1) begin n_bad++; $display("FAIL beats_accepted: got %0b want 1", drv_ok); end
    n_cmp++;
    if (served != exp_pre.size()) begin n_bad++; $display("FAIL perm_count: got %0d want %0d", served, exp_pre.size()); end
    n_cmp++;
    if (done_o !== 1'b1) begin n_bad++; $display("FAIL done_o: got %b want 1", done_o); end
    n_cmp++;
    if (busy_o !== 1'b0 || perm_req_o !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_done: busy %b req %b want 0 0", busy_o, perm_req_o);
    end
    n_cmp++;
    if (state_o !== fin) begin
      n_bad++;
      $display("FAIL final_state lane %0d: got %h want %h", diff_lane(state_o, fin),
               state_o[diff_lane(state_o, fin)%5][diff_lane(state_o, fin)/5],
               fin[diff_lane(state_o, fin)%5][diff_lane(state_o, fin)/5]);
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (s_if.tready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", s_if.tready); end
    n_cmp++; if (perm_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_perm_req: got %b want 0", perm_req_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_o); end
    n_cmp++; if (state_o !== '0) begin n_bad++; $display("FAIL rst_state: lane0 got %h want 0", state_o[0][0]); end
  endtask

  task automatic test_empty();
    int served;
    run_msg(1, 0, 2, served);
    n_cmp++;
    if (served != 1) begin n_bad++; $display("FAIL empty_perms: got %0d want 1", served); end
    n_cmp++;
    if (first_snap[0][0] !== 64'h06) begin n_bad++; $display("FAIL empty_lane0: got %h want 6", first_snap[0][0]); end
    n_cmp++;
    if (first_snap[1][3] !== 64'h8000_0000_0000_0000) begin
      n_bad++; $display("FAIL empty_lane16: got %h want 8000000000000000", first_snap[1][3]);
    end
  endtask

  task automatic test_exact_fill();
    int served;
    for (int i = 0; i < 256; i++) msg[i] = 8'(i * 13 + 5);
    run_msg(1, 136, 2, served);
    n_cmp++;
    if (served != 2) begin n_bad++; $display("FAIL exact_perms: got %0d want 2", served); end
    n_cmp++;
    if (post1[0] !== 1'b0) begin n_bad++; $display("FAIL exact_pad_ready: got %b want 0", post1[0]); end
  endtask

  task automatic test_carry();
    int served;
    for (int i = 0; i < 256; i++) msg[i] = 8'(i * 7 + 1);
    run_msg(1, 160, 2, served);
    n_cmp++;
    if (served != 2) begin n_bad++; $display("FAIL carry_perms: got %0d want 2", served); end
    n_cmp++;
    if (post1[0] !== 1'b0 || post2[0] !== 1'b0) begin
      n_bad++; $display("FAIL carry_pad_ready: got %b %b want 0 0", post1[0], post2[0]);
    end
  endtask

  task automatic test_shake_abc();
    int served;
    msg[0] = 8'h61;
    msg[1] = 8'h62;
    msg[2] = 8'h63;
    run_msg(4, 3, 2, served);
    n_cmp++;
    if (first_snap[0][0] !== 64'h1F63_6261) begin n_bad++; $display("FAIL abc_lane0: got %h want 1f636261", first_snap[0][0]); end
    n_cmp++;
    if (first_snap[0][4] !== 64'h8000_0000_0000_0000) begin
      n_bad++; $display("FAIL abc_lane20: got %h want 8000000000000000", first_snap[0][4]);
    end
  endtask

  task automatic test_hold();
    int served;
    for (int i = 0; i < 256; i++) msg[i] = 8'(255 - i);
    run_msg(1, 200, 20, served);
    n_cmp++;
    if (hold_ready_bad !== 1'b0) begin n_bad++; $display("FAIL hold_ready_low: got %b want 0", hold_ready_bad); end
    n_cmp++;
    if (hold_stable_bad !== 1'b0) begin n_bad++; $display("FAIL hold_state_stable: got %b want 0", hold_stable_bad); end
  endtask

  task automatic test_rst_in_perm();
    bit ok, found;
    build_model(1, 0);
    pulse_start(3'd1);
    drive_msg(0, ok);
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      if (perm_req_o === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL rstperm_req_seen: got 0 want 1"); end
    rst = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    perm_state_i = '1;
    perm_done_i  = 1'b1;
    @(negedge clk);
    perm_done_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || perm_req_o !== 1'b0) begin
      n_bad++; $display("FAIL rstperm_flags: busy %b done %b req %b want 0 0 0", busy_o, done_o, perm_req_o);
    end
    n_cmp++;
    if (state_o !== '0) begin n_bad++; $display("FAIL rstperm_state: lane0 got %h want 0", state_o[0][0]); end
  endtask

  task automatic test_err();
    pulse_start(3'd1);
    s_if.tdata  = '1;
    s_if.tkeep  = 32'h0000_FFFF;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    n_cmp++;
    if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_short_beat: got %b want 1", err_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_start(3'd6);
    n_cmp++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL err_bad_mode: err %b busy %b want 1 0", err_o, busy_o);
    end
    pulse_start(3'd3);
    n_cmp++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      n_bad++; $display("FAIL err_cleared: err %b busy %b want 0 1", err_o, busy_o);
    end
  endtask

  initial begin
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b0;
    for (int i = 0; i < 256; i++) msg[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_empty();
    test_exact_fill();
    test_carry();
    test_shake_abc();
    test_hold();
    test_rst_in_perm();
    test_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
